// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NPORT start/ready/valid requesters onto a single
// downstream memory port. Grants come from round-robin or fixed priority.
// At most one read can be outstanding. Writes complete when they are accepted.
module mem_port_arbiter #(
  parameter int NPORT      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NPORT-1:0]            port_cmd_start,
  input  logic [NPORT-1:0]            port_cmd_write,
  output logic [NPORT-1:0]            port_cmd_ready,
  input  logic [NPORT*ADDR_WIDTH-1:0] port_addr,
  input  logic [NPORT*DATA_WIDTH-1:0] port_wdata,
  input  logic [NPORT*DATA_WIDTH-1:0] port_wmask,
  output logic [DATA_WIDTH-1:0]       port_rdata,
  output logic [NPORT-1:0]            port_rdata_valid,
  output logic                        mem_cmd_start,
  output logic                        mem_cmd_write,
  input  logic                        mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic [DATA_WIDTH-1:0]       mem_wmask,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_rdata_valid
);

  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_READ = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   owner_reg, owner_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;

  logic [ADDR_WIDTH-1:0] addr_arr  [NPORT];
  logic [DATA_WIDTH-1:0] wdata_arr [NPORT];
  logic [DATA_WIDTH-1:0] wmask_arr [NPORT];
  logic [PTR_W-1:0]      scan_idx  [NPORT];
  logic [NPORT-1:0]      scan_req;

  logic                  grant_valid;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      ptr_after_grant;

  // Unpack the flat channel buses and build the scan order. Scan slot gi
  // looks at channel (rr_ptr + gi) mod NPORT in round-robin mode, and at
  // channel gi in fixed mode.
  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_chan
      assign addr_arr[gi]  = port_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = port_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wmask_arr[gi] = port_wmask[gi*DATA_WIDTH +: DATA_WIDTH];
      assign scan_idx[gi]  = (RR_MODE != 0)
                             ? PTR_W'((32'(rr_ptr_reg) + 32'(gi)) % NPORT)
                             : PTR_W'(gi);
      assign scan_req[gi]  = port_cmd_start[scan_idx[gi]];
    end
  endgenerate

  // Grant selection: the earliest scan slot holding a request wins.
  // The loop walks backwards so that the lowest slot is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (scan_req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[k];
      end
    end
  end

  // Pointer value after serving the granted channel. It wraps NPORT-1 -> 0.
  assign ptr_after_grant = (grant_idx == PTR_W'(NPORT - 1)) ? '0
                                                            : grant_idx + PTR_W'(1);

  // State register: arbiter state, read owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Next-state logic. State changes only on acceptance or on read completion.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid && mem_cmd_ready) begin
          if (RR_MODE != 0) begin
            rr_ptr_next = ptr_after_grant;
          end
          if (!port_cmd_write[grant_idx]) begin
            state_next = WAIT_READ;
            owner_next = grant_idx;
          end
        end
      end
      WAIT_READ: begin
        if (mem_rdata_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The request path is a pure mux from the granted channel.
  // All handshakes are forced low while reset is held.
  always_comb begin
    mem_cmd_start    = 1'b0;
    port_cmd_ready   = '0;
    port_rdata_valid = '0;
    mem_cmd_write    = port_cmd_write[grant_idx];
    mem_addr         = addr_arr[grant_idx];
    mem_wdata        = wdata_arr[grant_idx];
    mem_wmask        = wmask_arr[grant_idx];
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          mem_cmd_start = grant_valid;
          if (grant_valid) begin
            port_cmd_ready[grant_idx] = mem_cmd_ready;
          end
        end
        WAIT_READ: begin
          port_rdata_valid[owner_reg] = mem_rdata_valid;
        end
        default: ;
      endcase
    end
  end

  // Read data is broadcast. Only the valid bits say which channel owns it.
  assign port_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Instance A is 2-channel round-robin and
// instance B is 4-channel fixed priority. The directed scenarios are followed
// by randomized traffic that is checked against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // Instance A: NPORT=2, round-robin
  logic [1:0]  a_start, a_write, a_ready, a_rvalid;
  logic [63:0] a_addr, a_wdata, a_wmask;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mwmask, a_mrdata;
  logic        a_mstart, a_mwrite, a_mready, a_mrvalid;

  // Instance B: NPORT=4, fixed priority
  logic [3:0]   b_start, b_write, b_ready, b_rvalid;
  logic [127:0] b_addr, b_wdata, b_wmask;
  logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mwmask, b_mrdata;
  logic         b_mstart, b_mwrite, b_mready, b_mrvalid;

  mem_port_arbiter #(.NPORT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .port_cmd_start(a_start), .port_cmd_write(a_write), .port_cmd_ready(a_ready),
    .port_addr(a_addr), .port_wdata(a_wdata), .port_wmask(a_wmask),
    .port_rdata(a_rdata), .port_rdata_valid(a_rvalid),
    .mem_cmd_start(a_mstart), .mem_cmd_write(a_mwrite), .mem_cmd_ready(a_mready),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wmask(a_mwmask),
    .mem_rdata(a_mrdata), .mem_rdata_valid(a_mrvalid)
  );

  mem_port_arbiter #(.NPORT(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .port_cmd_start(b_start), .port_cmd_write(b_write), .port_cmd_ready(b_ready),
    .port_addr(b_addr), .port_wdata(b_wdata), .port_wmask(b_wmask),
    .port_rdata(b_rdata), .port_rdata_valid(b_rvalid),
    .mem_cmd_start(b_mstart), .mem_cmd_write(b_mwrite), .mem_cmd_ready(b_mready),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wmask(b_mwmask),
    .mem_rdata(b_mrdata), .mem_rdata_valid(b_mrvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the negedge. Outputs are sampled 1 time unit later.
  task automatic test_reset();
    rst_n = 1'b0;
    a_start = 2'b11; a_write = 2'b00; a_addr = '0; a_wdata = '0; a_wmask = '0;
    a_mready = 1'b1; a_mrdata = 32'h0; a_mrvalid = 1'b1;
    b_start = 4'hF; b_write = 4'h0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    b_mready = 1'b1; b_mrdata = 32'h0; b_mrvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (a_mstart !== 1'b0) begin n_err++; $display("FAIL rst_a_mstart got %b exp 0", a_mstart); end
    n_cmp++; if (a_ready !== 2'b00) begin n_err++; $display("FAIL rst_a_ready got %b exp 00", a_ready); end
    n_cmp++; if (a_rvalid !== 2'b00) begin n_err++; $display("FAIL rst_a_rvalid got %b exp 00", a_rvalid); end
    n_cmp++; if (b_ready !== 4'b0000) begin n_err++; $display("FAIL rst_b_ready got %b exp 0000", b_ready); end
    @(negedge clk);
    rst_n = 1'b1; a_start = 2'b00; b_start = 4'h0; a_mrvalid = 1'b0; b_mrvalid = 1'b0;
    #1;
    n_cmp++; if (a_mstart !== 1'b0) begin n_err++; $display("FAIL idle_mstart got %b exp 0", a_mstart); end
    n_cmp++; if (a_ready !== 2'b00) begin n_err++; $display("FAIL idle_ready got %b exp 00", a_ready); end
    n_cmp++; if (a_rvalid !== 2'b00) begin n_err++; $display("FAIL idle_rvalid got %b exp 00", a_rvalid); end
    $display("test_reset done");
  endtask

  task automatic test_rr_alternate();
    logic [31:0] exp_addr;
    logic [1:0]  exp_rdy;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_start = 2'b11; a_write = 2'b11; a_addr = {32'h0000_0020, 32'h0000_0010}; a_mready = 1'b1;
      #1;
      exp_addr = (k % 2 == 0) ? 32'h10 : 32'h20;
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (a_maddr !== exp_addr) begin n_err++; $display("FAIL rr_addr[%0d] got %h exp %h", k, a_maddr, exp_addr); end
      n_cmp++; if (a_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d] got %b exp %b", k, a_ready, exp_rdy); end
      $display("rr write cycle %0d addr %h ready %b", k, a_maddr, a_ready);
    end
    @(negedge clk);
    a_start = 2'b00;
  endtask

  task automatic test_fixed_reads();
    b_write = 4'h0; b_mready = 1'b1; b_mrvalid = 1'b0;
    b_addr = {32'hC0, 32'h80, 32'h40, 32'h0};
    b_start = 4'b1010;
    #1;
    n_cmp++; if (b_ready !== 4'b0010) begin n_err++; $display("FAIL fx_grant1 got %b exp 0010", b_ready); end
    n_cmp++; if (b_maddr !== 32'h40) begin n_err++; $display("FAIL fx_addr1 got %h exp 40", b_maddr); end
    @(negedge clk); b_start = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (b_mstart !== 1'b0 || b_ready !== 4'b0000) begin n_err++; $display("FAIL fx_wait1 got start %b ready %b exp 0/0000", b_mstart, b_ready); end
      @(negedge clk);
    end
    b_mrvalid = 1'b1; b_mrdata = 32'hAAAA_0001;
    #1;
    n_cmp++; if (b_rvalid !== 4'b0010) begin n_err++; $display("FAIL fx_valid1 got %b exp 0010", b_rvalid); end
    n_cmp++; if (b_rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL fx_rdata1 got %h exp aaaa0001", b_rdata); end
    n_cmp++; if (b_ready !== 4'b0000) begin n_err++; $display("FAIL fx_bubble got %b exp 0000", b_ready); end
    $display("fixed read ch1 data %h valid %b", b_rdata, b_rvalid);
    @(negedge clk); b_mrvalid = 1'b0;
    #1;
    n_cmp++; if (b_ready !== 4'b1000) begin n_err++; $display("FAIL fx_grant3 got %b exp 1000", b_ready); end
    n_cmp++; if (b_maddr !== 32'hC0) begin n_err++; $display("FAIL fx_addr3 got %h exp c0", b_maddr); end
    @(negedge clk); b_start = 4'b0000;
    @(negedge clk);
    @(negedge clk); b_mrvalid = 1'b1; b_mrdata = 32'hAAAA_0003;
    #1;
    n_cmp++; if (b_rvalid !== 4'b1000) begin n_err++; $display("FAIL fx_valid3 got %b exp 1000", b_rvalid); end
    $display("fixed read ch3 data %h valid %b", b_rdata, b_rvalid);
    @(negedge clk); b_mrvalid = 1'b0;
  endtask

  task automatic test_read_blocks_write();
    @(negedge clk);
    a_start = 2'b01; a_write = 2'b00; a_addr = {32'h200, 32'h100}; a_wdata = {32'h1234_5678, 32'h0};
    a_mready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 2'b01 || a_maddr !== 32'h100) begin n_err++; $display("FAIL rbw_read got ready %b addr %h exp 01/100", a_ready, a_maddr); end
    @(negedge clk); a_start = 2'b10; a_write = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (a_ready !== 2'b00) begin n_err++; $display("FAIL rbw_blocked[%0d] got %b exp 00", k, a_ready); end
      @(negedge clk);
    end
    a_mrvalid = 1'b1; a_mrdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (a_rvalid !== 2'b01 || a_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rbw_rdata got valid %b data %h exp 01/deadbeef", a_rvalid, a_rdata); end
    @(negedge clk); a_mrvalid = 1'b0;
    #1;
    n_cmp++; if (a_ready !== 2'b10 || a_mwrite !== 1'b1 || a_mwdata !== 32'h1234_5678) begin n_err++; $display("FAIL rbw_write got ready %b wr %b wdata %h exp 10/1/12345678", a_ready, a_mwrite, a_mwdata); end
    $display("read ch0 then write ch1 ready %b", a_ready);
    @(negedge clk); a_start = 2'b00;
  endtask

  task automatic test_backpressure();
    a_start = 2'b10; a_write = 2'b10; a_addr = {32'h0000_0444, 32'h0}; a_mready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (a_ready !== 2'b00 || a_maddr !== 32'h444 || a_mstart !== 1'b1) begin n_err++; $display("FAIL bp_stall[%0d] got ready %b addr %h start %b", k, a_ready, a_maddr, a_mstart); end
      @(negedge clk);
    end
    a_mready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 2'b10) begin n_err++; $display("FAIL bp_accept got %b exp 10", a_ready); end
    $display("backpressure released ready %b", a_ready);
    @(negedge clk); a_start = 2'b00;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      a_start = 2'b01; a_write = 2'b01; a_mready = 1'b1;
      a_addr = {32'h0, 32'h500 + 32'(k) * 4};
      #1;
      n_cmp++; if (a_ready !== 2'b01 || a_maddr !== 32'h500 + 32'(k) * 4) begin n_err++; $display("FAIL b2b[%0d] got ready %b addr %h", k, a_ready, a_maddr); end
      $display("back-to-back write %0d addr %h", k, a_maddr);
      @(negedge clk);
    end
    a_start = 2'b00;
  endtask

  task automatic test_retraction();
    @(negedge clk);
    b_write = 4'b1100; b_mready = 1'b0; b_addr = {32'hC3, 32'hC2, 32'h0, 32'h0};
    b_start = 4'b1100;
    #1;
    n_cmp++; if (b_maddr !== 32'hC2) begin n_err++; $display("FAIL retr_before got %h exp c2", b_maddr); end
    b_start = 4'b1000;
    #1;
    n_cmp++; if (b_maddr !== 32'hC3) begin n_err++; $display("FAIL retr_after got %h exp c3", b_maddr); end
    b_mready = 1'b1;
    #1;
    n_cmp++; if (b_ready !== 4'b1000) begin n_err++; $display("FAIL retr_ready got %b exp 1000", b_ready); end
    $display("retraction regrant addr %h", b_maddr);
    @(negedge clk); b_start = 4'b0000;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    a_start = 2'b01; a_write = 2'b00; a_addr = {32'h0000_0600, 32'h0000_0300}; a_mready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 2'b01) begin n_err++; $display("FAIL rmr_accept got %b exp 01", a_ready); end
    @(negedge clk); a_start = 2'b00;
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++; if (a_mstart !== 1'b0 || a_rvalid !== 2'b00) begin n_err++; $display("FAIL rmr_inreset got start %b valid %b", a_mstart, a_rvalid); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk); a_mrvalid = 1'b1; a_mrdata = 32'h0BAD_0BAD; a_start = 2'b11; a_write = 2'b11;
    #1;
    n_cmp++; if (a_rvalid !== 2'b00) begin n_err++; $display("FAIL rmr_late_valid got %b exp 00", a_rvalid); end
    n_cmp++; if (a_ready !== 2'b01 || a_maddr !== 32'h300) begin n_err++; $display("FAIL rmr_grant got ready %b addr %h exp 01/300", a_ready, a_maddr); end
    $display("reset mid read: late valid %b, regrant %b", a_rvalid, a_ready);
    @(negedge clk); a_mrvalid = 1'b0; a_start = 2'b00;
  endtask

  // Random traffic on instance A. The model tracks the pending requests, the
  // channel served last, and whether a read is in flight.
  task automatic test_random_rr();
    logic [1:0]  req, wr, exp_rdy, exp_val;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] wm [2];
    int ptr, owner, cnt, g, idx;
    bit busy;
    req = '0; wr = '0; ptr = 0; owner = 0; cnt = 0; busy = 0;
    for (int i = 0; i < 2; i++) begin ad[i] = 0; wd[i] = 0; wm[i] = 0; end
    @(negedge clk); rst_n = 1'b0; a_start = '0; a_mrvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1; wr[i] = 1'($urandom_range(0, 1));
          ad[i] = $urandom; wd[i] = $urandom; wm[i] = $urandom;
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      a_mready = ($urandom_range(0, 3) != 0);
      a_mrdata = $urandom;
      if (busy) begin cnt--; a_mrvalid = (cnt == 0); end
      else a_mrvalid = ($urandom_range(0, 7) == 0);
      a_start = req; a_write = wr;
      for (int i = 0; i < 2; i++) begin
        a_addr[i*32 +: 32] = ad[i]; a_wdata[i*32 +: 32] = wd[i]; a_wmask[i*32 +: 32] = wm[i];
      end
      #1;
      g = -1;
      for (int k = 0; k < 2; k++) begin
        idx = (ptr + k) % 2;
        if (g < 0 && req[idx]) g = idx;
      end
      exp_rdy = '0; exp_val = '0;
      if (!busy && g >= 0 && a_mready) exp_rdy[g] = 1'b1;
      if (busy && a_mrvalid) exp_val[owner] = 1'b1;
      n_cmp++; if (a_mstart !== (!busy && g >= 0)) begin n_err++; $display("FAIL rnd_a_start[%0d] got %b", cyc, a_mstart); end
      n_cmp++; if (a_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_a_ready[%0d] got %b exp %b", cyc, a_ready, exp_rdy); end
      n_cmp++; if (a_rvalid !== exp_val) begin n_err++; $display("FAIL rnd_a_valid[%0d] got %b exp %b", cyc, a_rvalid, exp_val); end
      n_cmp++; if (a_rdata !== a_mrdata) begin n_err++; $display("FAIL rnd_a_rdata[%0d] got %h exp %h", cyc, a_rdata, a_mrdata); end
      if (!busy && g >= 0) begin
        n_cmp++;
        if (a_maddr !== ad[g] || a_mwrite !== wr[g] || a_mwdata !== wd[g] || a_mwmask !== wm[g]) begin
          n_err++; $display("FAIL rnd_a_cmd[%0d] got addr %h wr %b exp ch%0d addr %h wr %b", cyc, a_maddr, a_mwrite, g, ad[g], wr[g]);
        end
      end
      if (!busy && g >= 0 && a_mready) begin
        ptr = (g + 1) % 2;
        if (!wr[g]) begin busy = 1; owner = g; cnt = $urandom_range(1, 4); end
        req[g] = 1'b0;
      end else if (busy && a_mrvalid) begin
        busy = 0;
      end
    end
    @(negedge clk); a_start = '0; a_mrvalid = 1'b0;
    $display("test_random_rr done");
  endtask

  // Random traffic on instance B: the lowest requesting index always wins.
  task automatic test_random_fixed();
    logic [3:0]  req, wr, exp_rdy, exp_val;
    logic [31:0] ad [4];
    logic [31:0] wd [4];
    logic [31:0] wm [4];
    int owner, cnt, g;
    bit busy;
    req = '0; wr = '0; owner = 0; cnt = 0; busy = 0;
    for (int i = 0; i < 4; i++) begin ad[i] = 0; wd[i] = 0; wm[i] = 0; end
    @(negedge clk); rst_n = 1'b0; b_start = '0; b_mrvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1; wr[i] = 1'($urandom_range(0, 1));
          ad[i] = $urandom; wd[i] = $urandom; wm[i] = $urandom;
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      b_mready = ($urandom_range(0, 3) != 0);
      b_mrdata = $urandom;
      if (busy) begin cnt--; b_mrvalid = (cnt == 0); end
      else b_mrvalid = ($urandom_range(0, 7) == 0);
      b_start = req; b_write = wr;
      for (int i = 0; i < 4; i++) begin
        b_addr[i*32 +: 32] = ad[i]; b_wdata[i*32 +: 32] = wd[i]; b_wmask[i*32 +: 32] = wm[i];
      end
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) if (g < 0 && req[k]) g = k;
      exp_rdy = '0; exp_val = '0;
      if (!busy && g >= 0 && b_mready) exp_rdy[g] = 1'b1;
      if (busy && b_mrvalid) exp_val[owner] = 1'b1;
      n_cmp++; if (b_mstart !== (!busy && g >= 0)) begin n_err++; $display("FAIL rnd_b_start[%0d] got %b", cyc, b_mstart); end
      n_cmp++; if (b_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_b_ready[%0d] got %b exp %b", cyc, b_ready, exp_rdy); end
      n_cmp++; if (b_rvalid !== exp_val) begin n_err++; $display("FAIL rnd_b_valid[%0d] got %b exp %b", cyc, b_rvalid, exp_val); end
      if (!busy && g >= 0) begin
        n_cmp++;
        if (b_maddr !== ad[g] || b_mwrite !== wr[g] || b_mwdata !== wd[g] || b_mwmask !== wm[g]) begin
          n_err++; $display("FAIL rnd_b_cmd[%0d] got addr %h wr %b exp ch%0d addr %h wr %b", cyc, b_maddr, b_mwrite, g, ad[g], wr[g]);
        end
      end
      if (!busy && g >= 0 && b_mready) begin
        if (!wr[g]) begin busy = 1; owner = g; cnt = $urandom_range(1, 4); end
        req[g] = 1'b0;
      end else if (busy && b_mrvalid) begin
        busy = 0;
      end
    end
    @(negedge clk); b_start = '0; b_mrvalid = 1'b0;
    $display("test_random_fixed done");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_rr_alternate();
    test_fixed_reads();
    test_read_blocks_write();
    test_backpressure();
    test_back_to_back();
    test_retraction();
    test_reset_mid_read();
    test_random_rr();
    test_random_fixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
